layer7_weight_loader: RTL and testbench

- Upstream feeder for the layer-7 local weight memory.
- On a start pulse, fetches WEIGHT_NUM 16-bit weights from external memory as packed 32-bit words through a req/ack read port.
- Streams them one per cycle on the write_weight_* interface. The local memory packs each group of 8 consecutive weights into one 128-bit row.
- Signals completion so the layer controller can begin issuing weight reads.

---
 rtl/layer7_weight_loader.sv | 122 ++++++++++++
 tb/tb_layer7_weight_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/layer7_weight_loader.sv
// Weight loader for the layer-7 local weight memory: fetches packed 32-bit words over a req/ack
// read port and streams them as 16-bit weights, lower half first, one per cycle.
module layer7_weight_loader #(
   parameter int unsigned WEIGHT_NUM  = 400,
   parameter int unsigned ADDR_STRIDE = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] base_addr,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        write_weight_signal,
   output logic [15:0] write_weight_data,
   output logic [15:0] write_weight_addr,
   output logic        busy,
   output logic        weight_store_done
);

   typedef enum logic [1:0] {StIdle, StReq, StLo, StHi} state_e;

   localparam logic [15:0] LastIdx = 16'(WEIGHT_NUM - 1);

   state_e      state_q, state_d;
   logic [31:0] base_q, base_d;
   logic [15:0] word_idx_q, word_idx_d;
   logic [15:0] weight_cnt_q, weight_cnt_d;
   logic [31:0] hold_q, hold_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         base_q       <= '0;
         word_idx_q   <= '0;
         weight_cnt_q <= '0;
         hold_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         word_idx_q   <= word_idx_d;
         weight_cnt_q <= weight_cnt_d;
         hold_q       <= hold_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      word_idx_d   = word_idx_q;
      weight_cnt_d = weight_cnt_q;
      hold_d       = hold_q;
      busy_d       = busy_q;
      done_d       = done_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               base_d       = base_addr;
               word_idx_d   = '0;
               weight_cnt_d = '0;
               done_d       = 1'b0;
               busy_d       = 1'b1;
               state_d      = StReq;
            end
         end
         StReq: begin
            // Ack only counts here; acks seen in any other state are dropped.
            if (mem_ack) begin
               hold_d     = mem_rdata;
               word_idx_d = word_idx_q + 16'd1;
               state_d    = StLo;
            end
         end
         StLo: begin
            weight_cnt_d = weight_cnt_q + 16'd1;
            state_d      = StHi;
         end
         StHi: begin
            weight_cnt_d = weight_cnt_q + 16'd1;
            if (weight_cnt_q == LastIdx) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = StIdle;
            end else begin
               state_d = StReq;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // All outputs decode flop state only, so nothing combinational passes from input to output.
   always_comb begin
      mem_req             = (state_q == StReq);
      mem_addr            = '0;
      write_weight_signal = (state_q == StLo) || (state_q == StHi);
      write_weight_data   = '0;
      write_weight_addr   = '0;
      if (mem_req) begin
         mem_addr = base_q + 32'(ADDR_STRIDE) * 32'(word_idx_q);
      end
      if (state_q == StLo) begin
         write_weight_data = hold_q[15:0];
      end else if (state_q == StHi) begin
         write_weight_data = hold_q[31:16];
      end
      if (write_weight_signal) begin
         write_weight_addr = weight_cnt_q;
      end
   end

   assign busy              = busy_q;
   assign weight_store_done = done_q;

endmodule

// File: tb/tb_layer7_weight_loader.sv
// Directed bench for layer7_weight_loader: a bench-side memory responder pushes expected weights
// into a scoreboard as it acks, and every write pulse pops and compares against it.
module tb_layer7_weight_loader;

   localparam int unsigned WeightNum = 400;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] base_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        write_weight_signal;
   logic [15:0] write_weight_data;
   logic [15:0] write_weight_addr;
   logic        busy;
   logic        weight_store_done;

   always #5 clk = ~clk;

   layer7_weight_loader #(
      .WEIGHT_NUM  (WeightNum),
      .ADDR_STRIDE (4)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .start               (start),
      .base_addr           (base_addr),
      .mem_req             (mem_req),
      .mem_addr            (mem_addr),
      .mem_ack             (mem_ack),
      .mem_rdata           (mem_rdata),
      .write_weight_signal (write_weight_signal),
      .write_weight_data   (write_weight_data),
      .write_weight_addr   (write_weight_addr),
      .busy                (busy),
      .weight_store_done   (weight_store_done)
   );

   int          passed = 0;
   int          total  = 0;
   logic [31:0] exp_q[$];
   logic [15:0] wmem[WeightNum];
   int          cyc = 0;
   int          t0 = 0;
   int          word_exp = 0;
   int          writes = 0;
   int          last_write_cyc = 0;
   int          req_hold = 0;
   int          stall_word = -1;
   int          stall_left = 0;
   bit          spurious_ack = 1'b0;
   logic [31:0] cur_base = '0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic check_outputs_zero(input string tag);
      check(tag, {mem_req, mem_addr, write_weight_signal, write_weight_data, write_weight_addr,
                  busy, weight_store_done}, '0);
   endtask

   // Sample on the falling edge, then drive inputs for the next rising edge.
   task automatic step();
      logic [31:0] e;
      @(negedge clk);
      cyc++;
      if (write_weight_signal) begin
         check("wr_queue_nonempty", 128'(exp_q.size() != 0), 128'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wr_addr_data", {write_weight_addr, write_weight_data}, e);
         end
         if (32'(write_weight_addr) < WeightNum) wmem[write_weight_addr] = write_weight_data;
         writes++;
         last_write_cyc = cyc;
      end
      start     = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      if (mem_req) begin
         check("mem_addr", mem_addr, cur_base + 32'(word_exp * 4));
         check("no_write_in_req", write_weight_signal, 1'b0);
         req_hold++;
         if (word_exp == stall_word && stall_left > 0) begin
            stall_left--;
         end else begin
            mem_ack   = 1'b1;
            mem_rdata = {16'(word_exp * 2 + 1), 16'(word_exp * 2)};
            exp_q.push_back({16'(word_exp * 2), 16'(word_exp * 2)});
            exp_q.push_back({16'(word_exp * 2 + 1), 16'(word_exp * 2 + 1)});
            if (word_exp == stall_word) check("stall_req_hold", req_hold, 6);
            word_exp++;
            req_hold = 0;
         end
      end else if (spurious_ack) begin
         mem_ack   = 1'b1;
         mem_rdata = 32'hDEAD_BEEF;
      end
   endtask

   // abort_at < 0 runs to completion; otherwise reset is raised after that write address.
   task automatic run_load(input logic [31:0] base, input bit spur_start, input int abort_at,
                           input bit check_timing);
      int guard;
      exp_q.delete();
      word_exp  = 0;
      writes    = 0;
      req_hold  = 0;
      cur_base  = base;
      start     = 1'b1;
      base_addr = base;
      t0        = cyc;
      step();
      check("busy_after_start", {busy, weight_store_done}, 2'b10);
      guard = 0;
      while (writes < WeightNum && guard < 3000) begin
         if (abort_at >= 0 && writes == abort_at + 1) break;
         step();
         if (spur_start && (cyc - t0 == 10 || cyc - t0 == 50)) begin
            start     = 1'b1;
            base_addr = 32'h5555_0000;
         end
         guard++;
      end
      if (abort_at >= 0) begin
         check("abort_point", writes, abort_at + 1);
         return;
      end
      check("write_count", writes, WeightNum);
      check("queue_drained", exp_q.size(), 0);
      if (check_timing) check("last_write_cycle", last_write_cyc - t0, 600);
      check("done_before_rise", weight_store_done, 1'b0);
      step();
      check("done_busy_after_load", {busy, weight_store_done}, 2'b01);
   endtask

   initial begin
      logic [127:0] row;
      logic [127:0] row_exp;
      rst       = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      repeat (2) step();
      check_outputs_zero("reset_outputs");
      rst = 1'b0;
      repeat (3) step();
      check_outputs_zero("idle_no_start");

      // Nominal load with zero-latency ack.
      run_load(32'h1000_0000, 1'b0, -1, 1'b1);
      check("mem_addr_final_word", cur_base + 32'((word_exp - 1) * 4), 32'h1000_031C);
      for (int r = 0; r < 50; r += 49) begin
         for (int j = 0; j < 8; j++) begin
            row[j*16 +: 16]     = wmem[r * 8 + j];
            row_exp[j*16 +: 16] = 16'(r * 8 + j);
         end
         check($sformatf("row_%0d", r), row, row_exp);
      end
      repeat (3) step();
      check("idle_after_load", {mem_req, write_weight_signal, busy, weight_store_done}, 4'b0001);

      // Ack stalled five cycles on word 3.
      stall_word = 3;
      stall_left = 5;
      run_load(32'h1000_0000, 1'b0, -1, 1'b0);
      check("stall_last_write_cycle", last_write_cyc - t0, 605);
      stall_word = -1;

      // Spurious starts while busy and spurious acks outside REQ.
      spurious_ack = 1'b1;
      run_load(32'h1000_0000, 1'b1, -1, 1'b1);
      spurious_ack = 1'b0;

      // Reset mid-load, then a fresh load at a new base.
      run_load(32'h1000_0000, 1'b0, 123, 1'b0);
      rst = 1'b1;
      repeat (3) step();
      check_outputs_zero("outputs_in_reset");
      rst = 1'b0;
      repeat (2) step();
      check_outputs_zero("idle_after_abort");
      run_load(32'h2000_0000, 1'b0, -1, 1'b1);

      // Back-to-back: start the cycle after done rises.
      run_load(32'h2000_0000, 1'b0, -1, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
